// File: rtl/mem_wb_writeback.sv
// -----------------------------------------------------------------------------
// mem_wb_writeback
//   MEM/WB pipeline register and writeback stage of the pipelined RV32I core.
//   On each posedge the memory-stage fields are captured, the load word is
//   extracted/extended, and the final writeback value is selected and stored.
//   The register file writes on the negedge, so ID sees the value in the same
//   cycle. rd/WE/result are also exported to the hazard unit for forwarding.
//
//   Optional feature macro: WB_INSTRET_EN
//     defined   -> instret counts retired instructions (wraps mod 2^CNT_W)
//     undefined -> instret is tied to zero, no counter is built
//
//   Ports
//     clk            posedge stage clock
//     rst            asynchronous, active-high reset
//     en             stage enable (0 = stall, all state holds)
//     flush          insert a bubble; wins over en
//     m_valid        MEM stage holds a real instruction
//     m_reg_write    instruction writes rd
//     m_rd           destination register
//     m_result_src   00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
//     m_funct3       load size/sign
//     m_alu_result   ALU result; [1:0] is the load byte offset
//     m_read_data    raw aligned word from data memory
//     m_pc_plus4     return address for JAL/JALR
//     m_imm_ext      extended immediate
//     w_valid        WB holds a real instruction
//     w_rd           register file A3 / hazard unit rd
//     w_result       register file WD3 / forwarding data
//     w_we           register file WE
//     instret        retired-instruction count
//
//   Handshake: there is no ready path. Flow control is en (stall) and flush
//   (kill). w_valid qualifies w_rd/w_result for the cycle after the capturing
//   edge; w_we is only ever high while w_valid is high and w_rd is non-zero.
// -----------------------------------------------------------------------------
module mem_wb_writeback #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             m_valid,
  input  logic             m_reg_write,
  input  logic [4:0]       m_rd,
  input  logic [1:0]       m_result_src,
  input  logic [2:0]       m_funct3,
  input  logic [XLEN-1:0]  m_alu_result,
  input  logic [XLEN-1:0]  m_read_data,
  input  logic [XLEN-1:0]  m_pc_plus4,
  input  logic [XLEN-1:0]  m_imm_ext,
  output logic             w_valid,
  output logic [4:0]       w_rd,
  output logic [XLEN-1:0]  w_result,
  output logic             w_we,
  output logic [CNT_W-1:0] instret
);

  logic            valid_q;
  logic            reg_write_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] result_q;

  logic [1:0]      load_off;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wb_val;

  // Load extraction. Half-word selection uses only off[1]; a misaligned
  // half is never produced by the core, so off[0] is simply ignored.
  always_comb begin
    load_off  = m_alu_result[1:0];
    load_byte = m_read_data[8*load_off +: 8];
    load_half = m_read_data[16*load_off[1] +: 16];
    load_val  = m_read_data;
    case (m_funct3)
      3'b000:  load_val = {{(XLEN-8){load_byte[7]}}, load_byte};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, load_byte};
      3'b001:  load_val = {{(XLEN-16){load_half[15]}}, load_half};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, load_half};
      default: load_val = m_read_data;
    endcase
  end

  // Writeback select is resolved before the register so w_result is a
  // clean flop output for both the regfile and the forwarding path.
  always_comb begin
    wb_val = m_alu_result;
    case (m_result_src)
      2'b00:   wb_val = m_alu_result;
      2'b01:   wb_val = load_val;
      2'b10:   wb_val = m_pc_plus4;
      default: wb_val = m_imm_ext;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      result_q    <= '0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      result_q    <= '0;
    end else if (en) begin
      valid_q     <= m_valid;
      reg_write_q <= m_reg_write;
      rd_q        <= m_rd;
      result_q    <= wb_val;
    end
  end

  assign w_valid  = valid_q;
  assign w_rd     = rd_q;
  assign w_result = result_q;
  // valid_q clears asynchronously with rst, so WE drops immediately on reset.
  assign w_we     = valid_q & reg_write_q & (rd_q != 5'd0);

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_q;

  // Counted on the capturing edge only, so a stalled instruction is
  // counted once and a flushed one is never counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (!flush && en && m_valid) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
module tb_mem_wb_writeback;

  localparam int XLEN  = 32;
  localparam int CNT_W = 64;
  localparam int EW    = 1 + 1 + 5 + XLEN + CNT_W;

  logic             clk;
  logic             rst;
  logic             en;
  logic             flush;
  logic             m_valid;
  logic             m_reg_write;
  logic [4:0]       m_rd;
  logic [1:0]       m_result_src;
  logic [2:0]       m_funct3;
  logic [XLEN-1:0]  m_alu_result;
  logic [XLEN-1:0]  m_read_data;
  logic [XLEN-1:0]  m_pc_plus4;
  logic [XLEN-1:0]  m_imm_ext;
  logic             w_valid;
  logic [4:0]       w_rd;
  logic [XLEN-1:0]  w_result;
  logic             w_we;
  logic [CNT_W-1:0] instret;

  mem_wb_writeback #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd),
    .m_result_src(m_result_src), .m_funct3(m_funct3),
    .m_alu_result(m_alu_result), .m_read_data(m_read_data),
    .m_pc_plus4(m_pc_plus4), .m_imm_ext(m_imm_ext),
    .w_valid(w_valid), .w_rd(w_rd), .w_result(w_result), .w_we(w_we),
    .instret(instret)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected post-edge output snapshot: {valid, we, rd, result, instret}
  logic [EW-1:0] exp_q[$];

  // Reference state (what WB should hold), updated per driven cycle.
  logic             ref_valid;
  logic             ref_rw;
  logic [4:0]       ref_rd;
  logic [XLEN-1:0]  ref_res;
  logic [CNT_W-1:0] ref_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] r;
    r = v;
    if (v >= (32'd1 << (bits - 1))) r = v + (32'hFFFF_FFFF << bits);
    return r;
  endfunction

  function automatic logic [31:0] model_result(input logic [1:0] src, input logic [2:0] f3,
                                               input logic [31:0] alu, input logic [31:0] rdata,
                                               input logic [31:0] pc4, input logic [31:0] imm);
    int unsigned off;
    logic [31:0] b, h;
    off = alu % 4;
    b = (rdata >> (8 * off)) & 32'hFF;
    h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    if (src == 2'd0) return alu;
    if (src == 2'd2) return pc4;
    if (src == 2'd3) return imm;
    if (f3 == 3'd0) return sext(b, 8);
    if (f3 == 3'd4) return b;
    if (f3 == 3'd1) return sext(h, 16);
    if (f3 == 3'd5) return h;
    return rdata;
  endfunction

  function automatic logic [CNT_W-1:0] model_instret();
`ifdef WB_INSTRET_EN
    return ref_cnt;
`else
    return '0;
`endif
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic drive(input logic i_en, input logic i_flush, input logic i_valid,
                       input logic i_rw, input logic [4:0] i_rd, input logic [1:0] i_src,
                       input logic [2:0] i_f3, input logic [31:0] i_alu,
                       input logic [31:0] i_rdata, input logic [31:0] i_pc4,
                       input logic [31:0] i_imm);
    @(negedge clk);
    en = i_en; flush = i_flush; m_valid = i_valid; m_reg_write = i_rw; m_rd = i_rd;
    m_result_src = i_src; m_funct3 = i_f3; m_alu_result = i_alu;
    m_read_data = i_rdata; m_pc_plus4 = i_pc4; m_imm_ext = i_imm;
    if (i_flush) begin
      ref_valid = 1'b0; ref_rw = 1'b0; ref_rd = 5'd0; ref_res = '0;
    end else if (i_en) begin
      ref_valid = i_valid; ref_rw = i_rw; ref_rd = i_rd;
      ref_res = model_result(i_src, i_f3, i_alu, i_rdata, i_pc4, i_imm);
      if (i_valid) ref_cnt = ref_cnt + 1;
    end
    exp_q.push_back({ref_valid, ref_valid & ref_rw & (ref_rd != 5'd0), ref_rd, ref_res,
                     model_instret()});
  endtask

  task automatic drive_rand();
    drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
          $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
          3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom);
  endtask

  // Idle inputs, hold reset across two edges, release on a negedge.
  task automatic finish_reset();
    en = 1'b0; flush = 1'b0; m_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_valid = 1'b0; ref_rw = 1'b0; ref_rd = 5'd0; ref_res = '0; ref_cnt = '0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // ---------------------------------------------------------------- monitor / scoreboard
  always begin
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_w_valid", 64'(w_valid), 64'(e[EW-1]));
      check("sb_w_we", 64'(w_we), 64'(e[EW-2]));
      check("sb_w_rd", 64'(w_rd), 64'(e[EW-3 -: 5]));
      check("sb_w_result", 64'(w_result), 64'(e[CNT_W +: XLEN]));
      check("sb_instret", instret, e[CNT_W-1:0]);
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [2:0]  ld_f3  [5];
    logic [1:0]  ld_off [5];
    logic [31:0] ld_exp [5];
    ld_f3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    ld_off = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    ld_exp = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

    rst = 1'b1; en = 1'b0; flush = 1'b0; m_valid = 1'b0; m_reg_write = 1'b0;
    m_rd = '0; m_result_src = '0; m_funct3 = '0; m_alu_result = '0;
    m_read_data = '0; m_pc_plus4 = '0; m_imm_ext = '0;
    ref_valid = 1'b0; ref_rw = 1'b0; ref_rd = 5'd0; ref_res = '0; ref_cnt = '0;
    #3;
    check("reset_w_valid", 64'(w_valid), 64'd0);
    check("reset_w_we", 64'(w_we), 64'd0);
    check("reset_w_rd", 64'(w_rd), 64'd0);
    check("reset_w_result", 64'(w_result), 64'd0);
    check("reset_instret", instret, 64'd0);
    finish_reset();

    // ALU writeback
    drive(1, 0, 1, 1, 5'd5, 2'b00, 3'd0, 32'h1234, 32'h0, 32'h0, 32'h0);
    after_edge();
    check("alu_w_rd", 64'(w_rd), 64'd5);
    check("alu_w_result", 64'(w_result), 64'h1234);
    check("alu_w_we", 64'(w_we), 64'd1);

    // Loads from a fixed word
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 1, 5'd10, 2'b01, ld_f3[i], {30'h4000_0000, ld_off[i]},
            32'h80FF_7F01, 32'h0, 32'h0);
      after_edge();
      check($sformatf("load_%0d_result", i), 64'(w_result), 64'(ld_exp[i]));
    end

    // x0 guard
    drive(1, 0, 1, 1, 5'd0, 2'b00, 3'd0, 32'hDEAD, 32'h0, 32'h0, 32'h0);
    after_edge();
    check("x0_w_valid", 64'(w_valid), 64'd1);
    check("x0_w_we", 64'(w_we), 64'd0);

    // Stall then flush (flush wins over en)
    drive(1, 0, 1, 1, 5'd7, 2'b00, 3'd0, 32'h77, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 5'd9, 2'b11, 3'd0, 32'h1, 32'h2, 32'h3, 32'h4);
      after_edge();
      check("stall_w_rd", 64'(w_rd), 64'd7);
      check("stall_w_result", 64'(w_result), 64'h77);
    end
    drive(1, 1, 1, 1, 5'd9, 2'b00, 3'd0, 32'h99, 32'h0, 32'h0, 32'h0);
    after_edge();
    check("flush_w_valid", 64'(w_valid), 64'd0);
    check("flush_w_we", 64'(w_we), 64'd0);
    check("flush_w_rd", 64'(w_rd), 64'd0);

    // JAL / LUI
    drive(1, 0, 1, 1, 5'd1, 2'b10, 3'd0, 32'h5, 32'h0, 32'h104, 32'h0);
    after_edge();
    check("jal_w_result", 64'(w_result), 64'h104);
    drive(1, 0, 1, 1, 5'd3, 2'b11, 3'd0, 32'h5, 32'h0, 32'h0, 32'hABCD_E000);
    after_edge();
    check("lui_w_result", 64'(w_result), 64'hABCD_E000);

    // Counter sequence from a fresh reset
    @(negedge clk);
    finish_reset();
    for (int i = 0; i < 4; i++)
      drive(1, 0, 1, 1, 5'(i + 1), 2'b00, 3'd0, 32'(i), 32'h0, 32'h0, 32'h0);
    drive(0, 0, 1, 1, 5'd8, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(0, 0, 1, 1, 5'd8, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1, 1, 1, 1, 5'd8, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1, 0, 0, 1, 5'd8, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    after_edge();
`ifdef WB_INSTRET_EN
    check("instret_seq", instret, 64'd4);
`else
    check("instret_tied_zero", instret, 64'd0);
`endif

    // Async reset during a stall with a live write pending
    drive(1, 0, 1, 1, 5'd12, 2'b00, 3'd0, 32'h55, 32'h0, 32'h0, 32'h0);
    drive(0, 0, 1, 1, 5'd12, 2'b00, 3'd0, 32'h55, 32'h0, 32'h0, 32'h0);
    after_edge();
    check("pre_rst_w_we", 64'(w_we), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_w_we", 64'(w_we), 64'd0);
    check("async_rst_w_valid", 64'(w_valid), 64'd0);
    check("async_rst_instret", instret, 64'd0);
    finish_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) drive_rand();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
